// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared types, constants and von Neumann pair decode for the TRNG byte packer
//
// Contents:
//   state_t          packer FSM state: FILL (collecting bits) / FULL (word waiting for consumer)
//   TRNG_BYTE_WIDTH  default bits per byte lane
//   vn_decode()      von Neumann pair decode, returns {keep, bit}
package trng_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int TRNG_BYTE_WIDTH = 8;

    // A pair is kept only when its two samples differ; the kept bit is the
    // first sample (01 -> 0, 10 -> 1). 00 and 11 carry no usable entropy.
    function automatic logic [1:0] vn_decode(input logic first, input logic second);
        return {first ^ second, first};
    endfunction

endpackage

// File: rtl/trng_vn_debias.sv
// rtl/trng_vn_debias.sv - von Neumann corrector with bypass for the raw TRNG sample stream
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   en           1 = pair-wise correction, 0 = samples pass straight through
//   bit_valid    raw sample strobe (already gated off by the packer while its word is full)
//   sample_bit   raw sample
//   acc_valid    an accepted bit is available this cycle (combinational)
//   acc_bit      the accepted bit
module trng_vn_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bit_valid,
    input  logic sample_bit,
    output logic acc_valid,
    output logic acc_bit
);

    logic       held_valid;
    logic       held_bit;
    logic       prev_en;
    logic       en_changed;
    logic       pair_ok;
    logic [1:0] pair;

    // A held half-pair only counts if the mode has not just changed; a sample
    // arriving in the change cycle starts a fresh pair instead.
    always_comb begin
        en_changed = en ^ prev_en;
        pair_ok    = held_valid && !en_changed;
        pair       = vn_decode(held_bit, sample_bit);
        acc_valid  = 1'b0;
        acc_bit    = sample_bit;
        if (bit_valid) begin
            if (!en) begin
                acc_valid = 1'b1;
            end else if (pair_ok) begin
                acc_valid = pair[1];
                acc_bit   = pair[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid <= 1'b0;
            held_bit   <= 1'b0;
            prev_en    <= 1'b0;
        end else begin
            prev_en <= en;
            if (bit_valid && en) begin
                if (pair_ok) begin
                    held_valid <= 1'b0;
                end else begin
                    held_valid <= 1'b1;
                    held_bit   <= sample_bit;
                end
            end else if (en_changed || !en) begin
                held_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/trng_byte_packer.sv
// rtl/trng_byte_packer.sv - packs (optionally debiased) TRNG bits into bytes and words for a byte-write register
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   bit_valid_i    raw sample strobe
//   bit_i          raw sample
//   vn_en_i        1 = von Neumann correction, 0 = raw pass-through
//   clr_ovf_i      clears overflow_o (a same-cycle drop wins)
//   we_o           one-hot byte-lane write enable, one cycle per completed byte
//   d_o            completed byte replicated on every lane
//   word_valid_o   downstream register holds a full word
//   word_ready_i   consumer takes the word
//   overflow_o     sticky: a sample was dropped while the word was full
//   byte_idx_o     bytes written into the current word
module trng_byte_packer
    import trng_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BYTE_WIDTH = TRNG_BYTE_WIDTH,
    localparam int WE_WIDTH  = WIDTH / BYTE_WIDTH,
    localparam int BIDX_W    = $clog2(WE_WIDTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_valid_i,
    input  logic                bit_i,
    input  logic                vn_en_i,
    input  logic                clr_ovf_i,
    output logic [WE_WIDTH-1:0] we_o,
    output logic [WIDTH-1:0]    d_o,
    output logic                word_valid_o,
    input  logic                word_ready_i,
    output logic                overflow_o,
    output logic [BIDX_W-1:0]   byte_idx_o
);

    localparam int CNT_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;

    state_t                state;
    state_t                state_next;
    logic [BYTE_WIDTH-1:0] shift_reg;
    logic [BYTE_WIDTH-1:0] byte_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  fill_valid;
    logic                  drop;
    logic                  byte_done;
    logic                  acc_valid;
    logic                  acc_bit;

    // Samples never reach the corrector while the word is full, so its
    // half-pair stays frozen until the consumer drains the word.
    always_comb begin
        fill_valid = bit_valid_i && (state == FILL);
        drop       = bit_valid_i && (state == FULL);
    end

    trng_vn_debias u_debias (
        .clk        (clk),
        .rst        (rst),
        .en         (vn_en_i),
        .bit_valid  (fill_valid),
        .sample_bit (bit_i),
        .acc_valid  (acc_valid),
        .acc_bit    (acc_bit)
    );

    // LSB-first: shifting right means the first accepted bit ends in bit 0.
    always_comb begin
        byte_next = {acc_bit, shift_reg[BYTE_WIDTH-1:1]};
        byte_done = acc_valid && (bit_cnt == CNT_W'(BYTE_WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // FULL is entered on the edge that ends the last-lane write pulse, so
    // word_valid_o rises once the downstream register has captured that lane.
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (we_o[WE_WIDTH-1]) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (word_ready_i) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            we_o         <= '0;
            d_o          <= '0;
            byte_idx_o   <= '0;
            word_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            we_o <= '0;
            if (acc_valid) begin
                shift_reg <= byte_next;
                if (byte_done) begin
                    bit_cnt    <= '0;
                    we_o       <= WE_WIDTH'(1) << byte_idx_o;
                    d_o        <= {WE_WIDTH{byte_next}};
                    byte_idx_o <= byte_idx_o + BIDX_W'(1);
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
            if ((state == FULL) && word_ready_i) begin
                byte_idx_o <= '0;
            end
            word_valid_o <= (state_next == FULL);
            if (drop) begin
                overflow_o <= 1'b1;
            end else if (clr_ovf_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trng_byte_packer.sv
// tb/tb_trng_byte_packer.sv - directed self-checking bench for trng_byte_packer
module tb_trng_byte_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_valid_i;
    logic        bit_i;
    logic        vn_en_i;
    logic        clr_ovf_i;
    logic [3:0]  we_o;
    logic [31:0] d_o;
    logic        word_valid_o;
    logic        word_ready_i;
    logic        overflow_o;
    logic [2:0]  byte_idx_o;

    int checks   = 0;
    int failures = 0;

    trng_byte_packer #(.WIDTH(32), .BYTE_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_valid_i  (bit_valid_i),
        .bit_i        (bit_i),
        .vn_en_i      (vn_en_i),
        .clr_ovf_i    (clr_ovf_i),
        .we_o         (we_o),
        .d_o          (d_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .overflow_o   (overflow_o),
        .byte_idx_o   (byte_idx_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid_i = 1'b1;
        bit_i       = b;
        tick();
        bit_valid_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
        end
    endtask

    task automatic send_pair(input logic a, input logic b);
        send_bit(a);
        send_bit(b);
    endtask

    initial begin
        rst          = 1'b1;
        bit_valid_i  = 1'b0;
        bit_i        = 1'b0;
        vn_en_i      = 1'b0;
        clr_ovf_i    = 1'b0;
        word_ready_i = 1'b0;
        tick();
        tick();
        check("rst_we", {28'd0, we_o}, 32'h0);
        check("rst_d", d_o, 32'h0);
        check("rst_wv", {31'd0, word_valid_o}, 32'h0);
        check("rst_ovf", {31'd0, overflow_o}, 32'h0);
        check("rst_bidx", {29'd0, byte_idx_o}, 32'h0);
        rst = 1'b0;
        tick();

        // Raw byte 0xA5 into lane 0
        for (int i = 0; i < 7; i++) begin
            send_bit(((8'hA5 >> i) & 8'h01) != 0);
        end
        check("a5_no_we_early", {28'd0, we_o}, 32'h0);
        send_bit(1'b1);
        check("a5_we", {28'd0, we_o}, 32'h1);
        check("a5_d", d_o, 32'hA5A5A5A5);
        check("a5_bidx", {29'd0, byte_idx_o}, 32'd1);
        tick();
        check("a5_we_one_cycle", {28'd0, we_o}, 32'h0);

        // Remaining three lanes, ready held low
        send_byte(8'h3C);
        check("lane1_we", {28'd0, we_o}, 32'h2);
        check("lane1_d", d_o, 32'h3C3C3C3C);
        send_byte(8'h0F);
        check("lane2_we", {28'd0, we_o}, 32'h4);
        send_byte(8'hF1);
        check("lane3_we", {28'd0, we_o}, 32'h8);
        check("lane3_d", d_o, 32'hF1F1F1F1);
        check("lane3_bidx", {29'd0, byte_idx_o}, 32'd4);
        check("lane3_wv_not_yet", {31'd0, word_valid_o}, 32'h0);
        tick();
        check("full_wv", {31'd0, word_valid_o}, 32'h1);
        check("full_we_idle", {28'd0, we_o}, 32'h0);

        // Drops while FULL
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
            check("full_drop_no_we", {28'd0, we_o}, 32'h0);
        end
        check("full_ovf_set", {31'd0, overflow_o}, 32'h1);
        check("full_bidx_hold", {29'd0, byte_idx_o}, 32'd4);
        check("full_wv_hold", {31'd0, word_valid_o}, 32'h1);
        check("full_d_hold", d_o, 32'hF1F1F1F1);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        check("ovf_clr", {31'd0, overflow_o}, 32'h0);
        clr_ovf_i = 1'b1;
        send_bit(1'b0);
        clr_ovf_i = 1'b0;
        check("ovf_set_wins", {31'd0, overflow_o}, 32'h1);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        check("ovf_clr2", {31'd0, overflow_o}, 32'h0);

        // Handshake; the sample in the handshake cycle is still dropped
        word_ready_i = 1'b1;
        send_bit(1'b1);
        word_ready_i = 1'b0;
        check("hs_wv_low", {31'd0, word_valid_o}, 32'h0);
        check("hs_bidx", {29'd0, byte_idx_o}, 32'd0);
        check("hs_ovf", {31'd0, overflow_o}, 32'h1);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        check("hs_ovf_clr", {31'd0, overflow_o}, 32'h0);

        // VN: 01,10,00,11,10,01 -> 0,1,1,0 ; then raw 1,0,1,0 -> 0x56
        vn_en_i = 1'b1;
        send_pair(1'b0, 1'b1);
        send_pair(1'b1, 1'b0);
        send_pair(1'b0, 1'b0);
        send_pair(1'b1, 1'b1);
        check("vn_no_we_a", {28'd0, we_o}, 32'h0);
        send_pair(1'b1, 1'b0);
        send_pair(1'b0, 1'b1);
        check("vn_no_we_b", {28'd0, we_o}, 32'h0);
        vn_en_i = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("vn_no_we_c", {28'd0, we_o}, 32'h0);
        send_bit(1'b0);
        check("vn_we", {28'd0, we_o}, 32'h1);
        check("vn_d", d_o, 32'h56565656);
        check("vn_bidx", {29'd0, byte_idx_o}, 32'd1);

        // Reset after 13 accepted bits
        send_byte(8'h3C);
        check("pre_rst_we", {28'd0, we_o}, 32'h2);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
        end
        rst = 1'b1;
        tick();
        check("mid_rst_we", {28'd0, we_o}, 32'h0);
        check("mid_rst_d", d_o, 32'h0);
        check("mid_rst_bidx", {29'd0, byte_idx_o}, 32'h0);
        check("mid_rst_wv", {31'd0, word_valid_o}, 32'h0);
        check("mid_rst_ovf", {31'd0, overflow_o}, 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_no_we", {28'd0, we_o}, 32'h0);
        send_byte(8'h96);
        check("post_rst_we", {28'd0, we_o}, 32'h1);
        check("post_rst_d", d_o, 32'h96969696);
        check("post_rst_bidx", {29'd0, byte_idx_o}, 32'd1);

        // Held half-pair discarded by a toggle of vn_en_i
        vn_en_i = 1'b1;
        send_bit(1'b1);
        vn_en_i = 1'b0;
        tick();
        vn_en_i = 1'b1;
        tick();
        send_pair(1'b0, 1'b1);
        vn_en_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1);
        end
        check("toggle_we", {28'd0, we_o}, 32'h2);
        check("toggle_d", d_o, 32'hFEFEFEFE);
        check("toggle_bidx", {29'd0, byte_idx_o}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
